// File: rtl/qar_icache_sa.sv
// Set-associative instruction cache between the QAR fetch stage and the external
// instruction bus: multi-word refill, per-set round-robin victim, fence.i invalidate.
module qar_icache_sa #(
    parameter int SETS       = 8,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_addr,
    output logic                 fetch_ready,
    output logic                 fetch_rvalid,
    output logic [31:0]          fetch_rdata,
    input  logic                 invalidate,
    output logic                 imem_valid,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] refill_words
);
    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
    localparam int IDX_W    = $clog2(SETS);
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W    = 30 - OFF_BITS - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, FILL_DONE} state_t;

    logic [31:0]      data_q   [SETS][WAYS][LINE_WORDS];
    logic [TAG_W-1:0] tag_q    [SETS][WAYS];
    logic [WAYS-1:0]  valid_q  [SETS];
    logic [WAY_W-1:0] victim_q [SETS];

    state_t           state;
    logic [29:0]      waddr_q;
    logic [WAY_W-1:0] way_q;
    logic [OFF_W-1:0] cnt_q;
    logic             inv_pend;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      line_base;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             beat;
    logic             last_beat;

    wire unused_byte_bits = ^fetch_addr[1:0];

    // With LINE_WORDS == 1 the mask forces the word offset to zero.
    assign off       = waddr_q[OFF_W-1:0] & OFF_W'(LINE_WORDS - 1);
    assign idx       = waddr_q[OFF_BITS +: IDX_W];
    assign tag       = waddr_q[29 -: TAG_W];
    assign line_base = {waddr_q & ~30'(LINE_WORDS - 1), 2'b00};

    assign fetch_ready = (state == IDLE) && !invalidate && !rst;
    assign busy        = (state != IDLE);
    assign beat        = (state == REFILL) && imem_ready;
    assign last_beat   = beat && (cnt_q == OFF_W'(LINE_WORDS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Line storage needs no reset: nothing reads it until a valid bit is set.
    always_ff @(posedge clk) begin
        if (beat) begin
            data_q[idx][way_q][cnt_q] <= imem_rdata;
            if (last_beat)
                tag_q[idx][way_q] <= tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            waddr_q      <= '0;
            way_q        <= '0;
            cnt_q        <= '0;
            inv_pend     <= 1'b0;
            fetch_rvalid <= 1'b0;
            fetch_rdata  <= '0;
            imem_valid   <= 1'b0;
            imem_addr    <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
            refill_words <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s]  <= '0;
                victim_q[s] <= '0;
            end
        end else begin
            fetch_rvalid <= 1'b0;
            if (invalidate)
                for (int s = 0; s < SETS; s++)
                    valid_q[s] <= '0;

            case (state)
                IDLE: begin
                    if (fetch_valid && fetch_ready) begin
                        waddr_q <= fetch_addr[31:2];
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        fetch_rvalid <= 1'b1;
                        fetch_rdata  <= data_q[idx][hit_way][off];
                        hit_count    <= hit_count + CNT_WIDTH'(1);
                        state        <= IDLE;
                    end else begin
                        miss_count <= miss_count + CNT_WIDTH'(1);
                        way_q      <= victim_q[idx];
                        cnt_q      <= '0;
                        imem_valid <= 1'b1;
                        imem_addr  <= line_base;
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (invalidate)
                        inv_pend <= 1'b1;
                    if (beat) begin
                        refill_words <= refill_words + CNT_WIDTH'(1);
                        cnt_q        <= cnt_q + OFF_W'(1);
                        if (!last_beat)
                            imem_addr <= line_base | (32'(cnt_q + OFF_W'(1)) << 2);
                    end
                    if (last_beat) begin
                        imem_valid <= 1'b0;
                        // A fence.i seen at any point of the refill keeps the line invalid.
                        if (!inv_pend && !invalidate)
                            valid_q[idx][way_q] <= 1'b1;
                        if (WAYS > 1)
                            victim_q[idx] <= victim_q[idx] + WAY_W'(1);
                        fetch_rvalid <= 1'b1;
                        fetch_rdata  <= (off == cnt_q) ? imem_rdata : data_q[idx][way_q][off];
                        state        <= FILL_DONE;
                    end
                end
                FILL_DONE: begin
                    inv_pend <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
